iccm_boot_ctrl: RTL and testbench
=================================

Name: iccm_boot_ctrl

Overview:
- Boot-time loader for the instruction memory.
- Takes a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word sequentially into the ICCM through the iccm_ctrl_* programming port.
- Holds the core in program-reset (prog_rst_no low) until a terminating end-marker word arrives or the memory fills, then releases the core.

Parameters:
- AW, 12, ICCM word-address width; capacity is 2**AW words.
- END_WORD, 32'h0000_0FFF, end-of-image marker word; terminates loading and is never written.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
- start_i  in  1  one-cycle pulse; begins or restarts a load
- rx_valid_i  in  1  one-cycle strobe; rx_byte_i is valid this cycle
- rx_byte_i  in  8  received byte
- iccm_ctrl_addr_o  out  AW  ICCM word address
- iccm_ctrl_wdata_o  out  32  ICCM write data
- iccm_ctrl_we_o  out  1  ICCM write strobe, one cycle per word
- prog_rst_no  out  1  core program reset, active low; low while not loaded
- busy_o  out  1  high in COLLECT or WRITE
- done_o  out  1  high in DONE
- ovf_o  out  1  sticky; load stopped because memory filled
- word_cnt_o  out  AW+1  number of words written in the current load

Behaviour:
- All outputs are registered. Clock is clk_i, reset is rst_ni: one clock, synchronous active-low reset.
- Reset values:
  - state = IDLE
  - iccm_ctrl_addr_o = 0, iccm_ctrl_wdata_o = 0, iccm_ctrl_we_o = 0
  - prog_rst_no = 0, busy_o = 0, done_o = 0, ovf_o = 0, word_cnt_o = 0
  - byte_idx = 0, assembly buffer = 0
- Reset asserted in any state, including mid-write, returns to these values on the next rising edge. A partial word is discarded.
- States are IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - prog_rst_no = 0; rx_valid_i is ignored.
  - start_i -> COLLECT, with addr = 0, word_cnt = 0, byte_idx = 0, ovf = 0.
- COLLECT:
  - Each rx_valid_i stores rx_byte_i into buffer[8*byte_idx +: 8]; byte_idx increments mod 4. Byte 0 maps to bits [7:0].
  - On the 4th byte, the assembled word W = {byte3, byte2, byte1, byte0}:
    - If W == END_WORD -> DONE. No write occurs; word_cnt is unchanged.
    - Otherwise iccm_ctrl_wdata_o <= W -> WRITE.
- WRITE (exactly one cycle):
  - iccm_ctrl_we_o = 1, with iccm_ctrl_addr_o and iccm_ctrl_wdata_o stable.
  - On exit: we = 0 and word_cnt increments.
  - If addr == 2**AW-1 -> DONE with ovf_o = 1, and addr holds.
  - Otherwise addr increments -> COLLECT.
- Byte arriving during WRITE:
  - When the next state is COLLECT, the byte is accepted as byte 0 of the next word. No bytes are lost at the maximum strobe rate of 1 per cycle.
  - When the next state is DONE (full), the byte is dropped.
- DONE:
  - prog_rst_no = 1 from the first DONE cycle; done_o = 1.
  - rx_valid_i is ignored.
  - start_i -> COLLECT with the same initialisation as IDLE->COLLECT. prog_rst_no returns to 0 in that same cycle, so the core is re-held for reprogramming.
- start_i while busy:
  - Restarts the load: addr = 0, word_cnt = 0, byte_idx = 0, ovf = 0.
  - If start_i and rx_valid_i coincide, start wins and the byte is discarded.
  - An in-flight WRITE cycle still completes its strobe; the restart applies on the following edge.
- iccm_ctrl_we_o is never high outside WRITE. prog_rst_no is never high outside DONE.
- Latency: the write strobe is asserted on the cycle after the 4th byte's strobe. The end marker reaches DONE one cycle after its 4th byte.

Test Plan:
- Reset, then start, then bytes 78 56 34 12, EF BE AD DE, FF 0F 00 00 -> writes addr0=0x12345678 and addr1=0xDEADBEEF, each with a 1-cycle we; DONE one cycle after the final byte; prog_rst_no=1, word_cnt_o=2, ovf_o=0.
- Bytes on back-to-back cycles (rx_valid_i held high for 12 bytes, last 4 = end marker) -> all bytes captured, 2 writes, no drops; byte 4 is accepted during WRITE.
- AW=2 build, stream 5 non-marker words -> writes to addr 0..3, DONE after the 4th write; ovf_o=1, word_cnt_o=4; 5th word's bytes ignored; addr holds 3.
- Mid-word rst_ni=0 after 2 bytes, then start and a full word 0xAABBCCDD -> written at addr0 with no residue from earlier bytes.
- In DONE, pulse start -> prog_rst_no falls the same edge busy_o rises; new image written from addr0, word_cnt_o resets to 0.
- start_i coincident with rx_valid_i in COLLECT after 3 bytes -> byte dropped, addr=0, byte_idx=0; no write strobe occurs.

Source files
------------

// File: rtl/iccm_boot_ctrl.sv
// ---------------------------------------------------------------------------
// iccm_boot_ctrl
//
// Boot-time loader for the instruction closely-coupled memory (ICCM).
// Bytes arriving from the UART receiver are assembled little-endian into
// 32-bit words, and each word is written sequentially into the ICCM through
// its programming port. The core is held in program reset until either the
// end-of-image marker word arrives or the memory fills up; then the core is
// released.
//
// Ports:
//   clk_i              system clock
//   rst_ni             synchronous active-low reset, sampled on rising clk_i
//   start_i            one-cycle pulse; begins or restarts a load
//   rx_valid_i         one-cycle strobe; rx_byte_i is valid this cycle
//   rx_byte_i          received byte
//   iccm_ctrl_addr_o   ICCM word address
//   iccm_ctrl_wdata_o  ICCM write data
//   iccm_ctrl_we_o     ICCM write strobe, one cycle per word
//   prog_rst_no        core program reset, active low; low until loaded
//   busy_o             high while collecting bytes or writing a word
//   done_o             high once the image has been loaded
//   ovf_o              sticky; loading stopped because the memory filled
//   word_cnt_o         number of words written in the current load
// ---------------------------------------------------------------------------
module iccm_boot_ctrl #(
    parameter int          AW       = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_byte_i,
    output logic [AW-1:0] iccm_ctrl_addr_o,
    output logic [31:0]   iccm_ctrl_wdata_o,
    output logic          iccm_ctrl_we_o,
    output logic          prog_rst_no,
    output logic          busy_o,
    output logic          done_o,
    output logic          ovf_o,
    output logic [AW:0]   word_cnt_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

    logic [1:0]    state_q,   state_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [31:0]   wdata_q,   wdata_d;
    logic [AW:0]   wordCnt_q, wordCnt_d;
    logic          ovf_q,     ovf_d;
    logic [1:0]    byteIdx_q, byteIdx_d;
    logic [31:0]   buf_q,     buf_d;
    logic          we_q;
    logic          progRstN_q;
    logic          busy_q;
    logic          done_q;

    // The fourth byte completes the word in the same cycle it arrives, so the
    // word is formed from the three buffered bytes plus the incoming byte.
    logic [31:0] assembledWord;
    assign assembledWord = {rx_byte_i, buf_q[23:0]};

    // Next-state logic for the loader. A start pulse always re-initialises the
    // load (address, count, byte position, overflow) and drops any byte that
    // coincides with it. The WRITE state is a single cycle; a byte arriving in
    // that cycle becomes byte 0 of the next word unless the memory just filled.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wordCnt_d = wordCnt_q;
        ovf_d     = ovf_q;
        byteIdx_d = byteIdx_q;
        buf_d     = buf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = COLLECT;
                    addr_d    = '0;
                    wordCnt_d = '0;
                    byteIdx_d = '0;
                    ovf_d     = 1'b0;
                    buf_d     = '0;
                end
            end

            COLLECT: begin
                if (start_i) begin
                    addr_d    = '0;
                    wordCnt_d = '0;
                    byteIdx_d = '0;
                    ovf_d     = 1'b0;
                    buf_d     = '0;
                end else if (rx_valid_i) begin
                    buf_d[{byteIdx_q, 3'b000} +: 8] = rx_byte_i;
                    byteIdx_d = byteIdx_q + 2'd1;
                    if (byteIdx_q == 2'd3) begin
                        // The end marker terminates the image and is never
                        // written to memory.
                        if (assembledWord == END_WORD) begin
                            state_d = DONE;
                        end else begin
                            wdata_d = assembledWord;
                            state_d = WRITE;
                        end
                    end
                end
            end

            WRITE: begin
                if (start_i) begin
                    // The strobe for this cycle is already registered, so the
                    // write still completes; the restart takes effect now.
                    state_d   = COLLECT;
                    addr_d    = '0;
                    wordCnt_d = '0;
                    byteIdx_d = '0;
                    ovf_d     = 1'b0;
                    buf_d     = '0;
                end else begin
                    wordCnt_d = wordCnt_q + 1'b1;
                    if (addr_q == ADDR_MAX) begin
                        // Last word of the memory written: stop, keep the
                        // address, and drop any byte arriving now.
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = COLLECT;
                        if (rx_valid_i) begin
                            buf_d[7:0] = rx_byte_i;
                            byteIdx_d  = 2'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The status outputs are registered from
    // the next state so that they line up exactly with the state they
    // describe: the write strobe is high only in WRITE and the core reset is
    // released only in DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wordCnt_q  <= '0;
            ovf_q      <= 1'b0;
            byteIdx_q  <= '0;
            buf_q      <= '0;
            we_q       <= 1'b0;
            progRstN_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wordCnt_q  <= wordCnt_d;
            ovf_q      <= ovf_d;
            byteIdx_q  <= byteIdx_d;
            buf_q      <= buf_d;
            we_q       <= (state_d == WRITE);
            progRstN_q <= (state_d == DONE);
            busy_q     <= (state_d == COLLECT) || (state_d == WRITE);
            done_q     <= (state_d == DONE);
        end
    end

    assign iccm_ctrl_addr_o  = addr_q;
    assign iccm_ctrl_wdata_o = wdata_q;
    assign iccm_ctrl_we_o    = we_q;
    assign prog_rst_no       = progRstN_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign ovf_o             = ovf_q;
    assign word_cnt_o        = wordCnt_q;

endmodule

// File: tb/tb_iccm_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iccm_boot_ctrl
//
// Directed bench for the ICCM boot loader. Two instances share the same
// stimulus: the default 4K-word build and a 4-word build used to exercise
// the memory-full path.
// ---------------------------------------------------------------------------
module tb_iccm_boot_ctrl;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        rxValid;
    logic [7:0]  rxByte;

    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        progRstN;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [12:0] wordCnt;

    logic [1:0]  sAddr;
    logic [31:0] sWdata;
    logic        sWe;
    logic        sProgRstN;
    logic        sBusy;
    logic        sDone;
    logic        sOvf;
    logic [2:0]  sWordCnt;

    int checks = 0;
    int errors = 0;

    iccm_boot_ctrl #(.AW(12)) dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .start_i          (start),
        .rx_valid_i       (rxValid),
        .rx_byte_i        (rxByte),
        .iccm_ctrl_addr_o (addr),
        .iccm_ctrl_wdata_o(wdata),
        .iccm_ctrl_we_o   (we),
        .prog_rst_no      (progRstN),
        .busy_o           (busy),
        .done_o           (done),
        .ovf_o            (ovf),
        .word_cnt_o       (wordCnt)
    );

    iccm_boot_ctrl #(.AW(2)) dutSmall (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .start_i          (start),
        .rx_valid_i       (rxValid),
        .rx_byte_i        (rxByte),
        .iccm_ctrl_addr_o (sAddr),
        .iccm_ctrl_wdata_o(sWdata),
        .iccm_ctrl_we_o   (sWe),
        .prog_rst_no      (sProgRstN),
        .busy_o           (sBusy),
        .done_o           (sDone),
        .ovf_o            (sOvf),
        .word_cnt_o       (sWordCnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one byte for a single cycle.
    task automatic applyStimulus(input logic [7:0] b);
        rxValid = 1'b1;
        rxByte  = b;
        tick();
        rxValid = 1'b0;
    endtask

    // Send a word little-endian, with idle cycles between bytes but none
    // after the last byte.
    task automatic sendWord(input logic [31:0] w, input int gap);
        logic [31:0] tmp;
        tmp = w;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(tmp[8*j +: 8]);
            if (j < 3) repeat (gap) tick();
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] streamWords [3];
        logic [31:0] fillWord;

        rstN    = 1'b0;
        start   = 1'b0;
        rxValid = 1'b0;
        rxByte  = 8'h00;
        repeat (2) tick();

        // Reset values.
        checkOutput("rst_addr",  32'(addr),     32'h0);
        checkOutput("rst_wdata", wdata,         32'h0);
        checkOutput("rst_we",    32'(we),       32'h0);
        checkOutput("rst_prog",  32'(progRstN), 32'h0);
        checkOutput("rst_busy",  32'(busy),     32'h0);
        checkOutput("rst_done",  32'(done),     32'h0);
        checkOutput("rst_ovf",   32'(ovf),      32'h0);
        checkOutput("rst_cnt",   32'(wordCnt),  32'h0);
        rstN = 1'b1;
        tick();
        rxValid = 1'b1;
        rxByte  = 8'hA5;
        tick();
        rxValid = 1'b0;
        checkOutput("idle_ignores_rx", 32'(busy), 32'h0);

        // Basic image: two words then the end marker, with gaps between bytes.
        $display("[TB] basic load");
        pulseStart();
        checkOutput("t1_busy", 32'(busy),     32'h1);
        checkOutput("t1_prog", 32'(progRstN), 32'h0);
        sendWord(32'h1234_5678, 1);
        checkOutput("t1_w0_we",    32'(we),   32'h1);
        checkOutput("t1_w0_addr",  32'(addr), 32'h0);
        checkOutput("t1_w0_wdata", wdata,     32'h1234_5678);
        tick();
        checkOutput("t1_w0_we_off", 32'(we),      32'h0);
        checkOutput("t1_w0_cnt",    32'(wordCnt), 32'h1);
        sendWord(32'hDEAD_BEEF, 2);
        checkOutput("t1_w1_we",    32'(we),   32'h1);
        checkOutput("t1_w1_addr",  32'(addr), 32'h1);
        checkOutput("t1_w1_wdata", wdata,     32'hDEAD_BEEF);
        tick();
        sendWord(32'h0000_0FFF, 1);
        checkOutput("t1_done", 32'(done),     32'h1);
        checkOutput("t1_prog", 32'(progRstN), 32'h1);
        checkOutput("t1_busy", 32'(busy),     32'h0);
        checkOutput("t1_we",   32'(we),       32'h0);
        checkOutput("t1_cnt",  32'(wordCnt),  32'h2);
        checkOutput("t1_ovf",  32'(ovf),      32'h0);
        rxValid = 1'b1;
        rxByte  = 8'h11;
        tick();
        rxValid = 1'b0;
        checkOutput("t1_done_ignores_rx", 32'(done), 32'h1);

        // Restart from DONE, then 12 bytes on consecutive cycles.
        $display("[TB] restart from done and back-to-back bytes");
        pulseStart();
        checkOutput("t2_prog", 32'(progRstN), 32'h0);
        checkOutput("t2_busy", 32'(busy),     32'h1);
        checkOutput("t2_done", 32'(done),     32'h0);
        checkOutput("t2_cnt",  32'(wordCnt),  32'h0);
        checkOutput("t2_addr", 32'(addr),     32'h0);
        streamWords[0] = 32'h0403_0201;
        streamWords[1] = 32'h0807_0605;
        streamWords[2] = 32'h0000_0FFF;
        for (int k = 0; k < 12; k++) begin
            rxValid = 1'b1;
            rxByte  = streamWords[k / 4][8*(k % 4) +: 8];
            tick();
            if (k == 3) begin
                checkOutput("t2_w0_we",    32'(we), 32'h1);
                checkOutput("t2_w0_wdata", wdata,   32'h0403_0201);
            end
            if (k == 7) begin
                checkOutput("t2_w1_we",    32'(we),   32'h1);
                checkOutput("t2_w1_addr",  32'(addr), 32'h1);
                checkOutput("t2_w1_wdata", wdata,     32'h0807_0605);
            end
        end
        rxValid = 1'b0;
        checkOutput("t2_done", 32'(done),    32'h1);
        checkOutput("t2_cnt",  32'(wordCnt), 32'h2);

        // Four-word memory: five words fill it and the fifth is dropped.
        $display("[TB] memory full");
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            fillWord = 32'h1111_1111 * (i + 1);
            sendWord(fillWord, 0);
            checkOutput("t3_we",    32'(sWe),   32'h1);
            checkOutput("t3_addr",  32'(sAddr), 32'(i));
            checkOutput("t3_wdata", sWdata,     fillWord);
            tick();
        end
        checkOutput("t3_done", 32'(sDone),     32'h1);
        checkOutput("t3_ovf",  32'(sOvf),      32'h1);
        checkOutput("t3_cnt",  32'(sWordCnt),  32'h4);
        checkOutput("t3_addr", 32'(sAddr),     32'h3);
        checkOutput("t3_prog", 32'(sProgRstN), 32'h1);
        sendWord(32'h5555_5555, 0);
        checkOutput("t3_5th_we", 32'(sWe), 32'h0);
        tick();
        checkOutput("t3_5th_cnt",  32'(sWordCnt), 32'h4);
        checkOutput("t3_5th_addr", 32'(sAddr),    32'h3);

        // Reset after two bytes of a word, then a fresh load.
        $display("[TB] reset mid-word");
        pulseStart();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("t4_busy", 32'(busy), 32'h0);
        pulseStart();
        sendWord(32'hAABB_CCDD, 0);
        checkOutput("t4_we",    32'(we),   32'h1);
        checkOutput("t4_addr",  32'(addr), 32'h0);
        checkOutput("t4_wdata", wdata,     32'hAABB_CCDD);
        tick();

        // Start coinciding with a byte after three bytes of a word.
        $display("[TB] start during collect");
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        start   = 1'b1;
        rxValid = 1'b1;
        rxByte  = 8'h04;
        tick();
        start   = 1'b0;
        rxValid = 1'b0;
        checkOutput("t5_we",   32'(we),      32'h0);
        checkOutput("t5_addr", 32'(addr),    32'h0);
        checkOutput("t5_cnt",  32'(wordCnt), 32'h0);
        checkOutput("t5_busy", 32'(busy),    32'h1);
        applyStimulus(8'h55);
        checkOutput("t5_no_we", 32'(we), 32'h0);
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        applyStimulus(8'h88);
        checkOutput("t5_we2",   32'(we),   32'h1);
        checkOutput("t5_addr2", 32'(addr), 32'h0);
        checkOutput("t5_wdata", wdata,     32'h8877_6655);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
